// File: rtl/param_stim_pkg.sv
// Shared types, pattern-mode constants and next-word arithmetic for param_stim_gen.
package param_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned MODE_COUNT = 0;
    localparam int unsigned MODE_WALK  = 1;
    localparam int unsigned MODE_LFSR  = 2;

    // Widest supported word; helpers operate at this width and callers truncate.
    localparam int unsigned MAX_WIDTH = 8;
    typedef logic [MAX_WIDTH-1:0] word_t;

    // Mask selecting the low 'width' bits.
    function automatic word_t width_mask(input int unsigned width);
        return word_t'((9'd1 << width) - 9'd1);
    endfunction

    // Maximal-length Fibonacci tap masks (bit positions of the XOR taps).
    function automatic word_t lfsr_taps(input int unsigned width);
        case (width)
            4:       return 8'h0C;
            5:       return 8'h14;
            6:       return 8'h30;
            7:       return 8'h60;
            8:       return 8'hB8;
            default: return 8'h0C;
        endcase
    endfunction

    // First word of a burst; an all-zero LFSR seed would lock up, so it becomes 1.
    function automatic word_t first_word(input int unsigned width,
                                         input int unsigned mode,
                                         input int unsigned seed);
        word_t s;
        s = word_t'(seed) & width_mask(width);
        case (mode)
            MODE_WALK: return 8'd1;
            MODE_LFSR: return (s == 8'd0) ? 8'd1 : s;
            default:   return 8'd0;
        endcase
    endfunction

    // Successor of d under the selected pattern, confined to 'width' bits.
    function automatic word_t next_word(input word_t d,
                                        input int unsigned width,
                                        input int unsigned mode);
        word_t m;
        m = width_mask(width);
        case (mode)
            MODE_WALK: return ((d << 1) | (d >> (width - 1))) & m;
            MODE_LFSR: return {d[MAX_WIDTH-2:0], ^(d & lfsr_taps(width))} & m;
            default:   return (d + 8'd1) & m;
        endcase
    endfunction

endpackage

// File: rtl/param_stim_pattern.sv
// Word register: loads the burst's first word or steps to the next pattern value.
module param_stim_pattern
    import param_stim_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MODE  = 0,
    parameter int unsigned SEED  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             adv_i,
    output logic [WIDTH-1:0] word_o
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    // Load has priority; otherwise hold unless the FSM asks for the next word.
    always_comb begin
        word_d = word_q;
        if (load_i) begin
            word_d = WIDTH'(first_word(WIDTH, MODE, SEED));
        end else if (adv_i) begin
            word_d = WIDTH'(next_word(word_t'(word_q), WIDTH, MODE));
        end
    end

    // Word storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/param_stim_gen.sv
// Burst transmitter: sends BURST_LEN pattern words over valid/ready with DELAY idle cycles between words.
module param_stim_gen
    import param_stim_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned DELAY     = 1,
    parameter int unsigned MODE      = 0,
    parameter int unsigned SEED      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned GAP_W = (DELAY > 1) ? $clog2(DELAY + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(DELAY);

    state_e           state_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] word_cnt_q;
    logic [GAP_W-1:0] gap_q;
    logic             load_c;
    logic             adv_c;

    // Strobes to the word register, decided from the same state/inputs as the FSM edge.
    always_comb begin
        load_c = 1'b0;
        adv_c  = 1'b0;
        case (state_q)
            ST_IDLE:  load_c = start && !stop;
            ST_DRIVE: adv_c  = !stop && ready && (word_cnt_q != LAST_IDX) && (DELAY == 0);
            ST_HOLD:  adv_c  = !stop && (gap_q <= GAP_W'(1));
            default:  ;
        endcase
    end

    // Burst sequencing: stop beats a same-edge accept; start is only honoured in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            word_cnt_q <= '0;
            gap_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_q    <= ST_DRIVE;
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        word_cnt_q <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (stop) begin
                        state_q    <= ST_IDLE;
                        valid_q    <= 1'b0;
                        busy_q     <= 1'b0;
                        word_cnt_q <= '0;
                        gap_q      <= '0;
                    end else if (ready) begin
                        if (word_cnt_q == LAST_IDX) begin
                            state_q    <= ST_DONE;
                            valid_q    <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            word_cnt_q <= '0;
                        end else begin
                            word_cnt_q <= word_cnt_q + CNT_W'(1);
                            if (DELAY != 0) begin
                                state_q <= ST_HOLD;
                                valid_q <= 1'b0;
                                gap_q   <= GAP_LOAD;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (stop) begin
                        state_q    <= ST_IDLE;
                        valid_q    <= 1'b0;
                        busy_q     <= 1'b0;
                        word_cnt_q <= '0;
                        gap_q      <= '0;
                    end else if (gap_q <= GAP_W'(1)) begin
                        state_q <= ST_DRIVE;
                        valid_q <= 1'b1;
                        gap_q   <= '0;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    param_stim_pattern #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .SEED  (SEED)
    ) u_pattern (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load_c),
        .adv_i  (adv_c),
        .word_o (data)
    );

    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_param_stim_gen.sv
// Bench for param_stim_gen: five parameterisations share one stimulus stream and are checked
// against a burst-level reference model, with directed tables for the named scenarios.
module tb_param_stim_gen;

    localparam int N = 5;
    // Per-instance parameters: WIDTH, BURST_LEN, DELAY, MODE, SEED.
    localparam int P_W  [N] = '{4, 4, 4, 8, 5};
    localparam int P_BL [N] = '{4, 16, 5, 8, 6};
    localparam int P_D  [N] = '{0, 0, 2, 1, 3};
    localparam int P_M  [N] = '{0, 2, 1, 0, 2};
    localparam int P_S  [N] = '{1, 1, 1, 1, 0};

    logic clk;
    logic rst_n;
    logic start;
    logic stop;
    logic ready;
    logic valid_w [N];
    logic busy_w  [N];
    logic done_w  [N];
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [7:0] d3;
    logic [4:0] d4;

    int checks;
    int failures;
    int acc3;

    int m_busy  [N];
    int m_valid [N];
    int m_done  [N];
    int m_idx   [N];
    int m_gap   [N];
    int m_data  [N];

    typedef struct {
        int st;
        int sp;
        int rd;
        int ev;
        int ed;
        int eb;
        int edn;
    } vec_t;

    vec_t tbl [9];
    int lfsr_exp [16];
    int walk_exp [5];

    param_stim_gen #(.WIDTH(4), .BURST_LEN(4),  .DELAY(0), .MODE(0), .SEED(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ready(ready),
        .valid(valid_w[0]), .data(d0), .busy(busy_w[0]), .done(done_w[0]));
    param_stim_gen #(.WIDTH(4), .BURST_LEN(16), .DELAY(0), .MODE(2), .SEED(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ready(ready),
        .valid(valid_w[1]), .data(d1), .busy(busy_w[1]), .done(done_w[1]));
    param_stim_gen #(.WIDTH(4), .BURST_LEN(5),  .DELAY(2), .MODE(1), .SEED(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ready(ready),
        .valid(valid_w[2]), .data(d2), .busy(busy_w[2]), .done(done_w[2]));
    param_stim_gen #(.WIDTH(8), .BURST_LEN(8),  .DELAY(1), .MODE(0), .SEED(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ready(ready),
        .valid(valid_w[3]), .data(d3), .busy(busy_w[3]), .done(done_w[3]));
    param_stim_gen #(.WIDTH(5), .BURST_LEN(6),  .DELAY(3), .MODE(2), .SEED(0)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ready(ready),
        .valid(valid_w[4]), .data(d4), .busy(busy_w[4]), .done(done_w[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic int dat(input int k);
        case (k)
            0:       return int'(d0);
            1:       return int'(d1);
            2:       return int'(d2);
            3:       return int'(d3);
            default: return int'(d4);
        endcase
    endfunction

    // Feedback bit from the Fibonacci polynomial taps (1-based tap t -> bit t-1).
    function automatic int lfsr_fb(input int v, input int w);
        case (w)
            5:       return ((v >> 4) ^ (v >> 2)) & 1;
            6:       return ((v >> 5) ^ (v >> 4)) & 1;
            7:       return ((v >> 6) ^ (v >> 5)) & 1;
            8:       return ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
            default: return ((v >> 3) ^ (v >> 2)) & 1;
        endcase
    endfunction

    // n-th word of a burst for instance k.
    function automatic int word_at(input int k, input int n);
        int w;
        int mask;
        int v;
        w    = P_W[k];
        mask = (1 << w) - 1;
        case (P_M[k])
            1: return 1 << (n % w);
            2: begin
                v = P_S[k] & mask;
                if (v == 0) v = 1;
                for (int i = 0; i < n; i++) v = ((v << 1) | lfsr_fb(v, w)) & mask;
                return v;
            end
            default: return n & mask;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_busy[k] = 0; m_valid[k] = 0; m_done[k] = 0;
            m_idx[k] = 0; m_gap[k] = 0; m_data[k] = 0;
        end
    endtask

    // Advance the reference model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            if (m_done[k] != 0) begin
                m_done[k] = 0;
            end else if (m_busy[k] == 0) begin
                if (start && !stop) begin
                    m_busy[k] = 1; m_valid[k] = 1; m_idx[k] = 0;
                    m_data[k] = word_at(k, 0);
                end
            end else if (stop) begin
                m_busy[k] = 0; m_valid[k] = 0; m_idx[k] = 0; m_gap[k] = 0;
            end else if (m_valid[k] != 0) begin
                if (ready) begin
                    if (m_idx[k] == P_BL[k] - 1) begin
                        m_busy[k] = 0; m_valid[k] = 0; m_done[k] = 1; m_idx[k] = 0;
                    end else begin
                        m_idx[k]++;
                        if (P_D[k] == 0) begin
                            m_data[k] = word_at(k, m_idx[k]);
                        end else begin
                            m_valid[k] = 0;
                            m_gap[k] = P_D[k];
                        end
                    end
                end
            end else begin
                m_gap[k]--;
                if (m_gap[k] == 0) begin
                    m_valid[k] = 1;
                    m_data[k] = word_at(k, m_idx[k]);
                end
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("u%0d_valid", k), int'(valid_w[k]), m_valid[k]);
            chk($sformatf("u%0d_busy", k),  int'(busy_w[k]),  m_busy[k]);
            chk($sformatf("u%0d_done", k),  int'(done_w[k]),  m_done[k]);
            chk($sformatf("u%0d_data", k),  dat(k),           m_data[k]);
        end
    endtask

    task automatic tick();
        if (rst_n && !stop && ready && valid_w[3]) acc3++;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse between edges; outputs must clear without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic settle();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    int found;
    int seen;

    initial begin
        checks = 0; failures = 0; acc3 = 0;
        start = 1'b0; stop = 1'b0; ready = 1'b0; rst_n = 1'b0;

        // u0 (count, 4 words, no gap): {start, stop, ready, valid, data, busy, done}
        tbl[0] = '{1, 0, 1, 1, 0, 1, 0};
        tbl[1] = '{0, 0, 1, 1, 1, 1, 0};
        tbl[2] = '{0, 0, 1, 1, 2, 1, 0};
        tbl[3] = '{0, 0, 1, 1, 3, 1, 0};
        tbl[4] = '{0, 0, 1, 0, 3, 0, 1};
        tbl[5] = '{1, 0, 1, 0, 3, 0, 0};
        tbl[6] = '{1, 0, 1, 1, 0, 1, 0};
        tbl[7] = '{0, 1, 1, 0, 0, 0, 0};
        tbl[8] = '{1, 1, 0, 0, 0, 0, 0};
        lfsr_exp = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};
        walk_exp = '{1, 2, 4, 8, 1};

        model_reset();
        #3;
        compare_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Count burst, start ignored in DONE, replay, stop over ready, start+stop in IDLE.
        for (int i = 0; i < 9; i++) begin
            start = 1'(tbl[i].st);
            stop  = 1'(tbl[i].sp);
            ready = 1'(tbl[i].rd);
            tick();
            chk($sformatf("tbl%0d_valid", i), int'(valid_w[0]), tbl[i].ev);
            chk($sformatf("tbl%0d_data", i),  dat(0),            tbl[i].ed);
            chk($sformatf("tbl%0d_busy", i),  int'(busy_w[0]),  tbl[i].eb);
            chk($sformatf("tbl%0d_done", i),  int'(done_w[0]),  tbl[i].edn);
        end
        start = 1'b0; stop = 1'b0;

        // LFSR 16-word sequence on u1 and walking one with 2-cycle gaps on u2.
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 17; t++) begin
            if (t < 16) begin
                chk("lfsr_valid", int'(valid_w[1]), 1);
                chk($sformatf("lfsr_data%0d", t), dat(1), lfsr_exp[t]);
            end else begin
                chk("lfsr_done", int'(done_w[1]), 1);
            end
            if (t < 13) begin
                chk($sformatf("walk_valid%0d", t), int'(valid_w[2]), (t % 3 == 0) ? 1 : 0);
                if (t % 3 == 0) chk("walk_data", dat(2), walk_exp[t / 3]);
            end else if (t == 13) begin
                chk("walk_done", int'(done_w[2]), 1);
            end
            tick();
        end
        settle();

        // Backpressure: ready low for 3 cycles while u3 presents its third word.
        acc3 = 0;
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int t = 0; t < 20 && found == 0; t++) begin
            if (valid_w[3] && dat(3) == 2) found = 1;
            else tick();
        end
        chk("bp_reach_word2", found, 1);
        ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("bp_hold_valid", int'(valid_w[3]), 1);
            chk("bp_hold_data", dat(3), 2);
        end
        ready = 1'b1;
        seen = 0;
        for (int t = 0; t < 40 && seen == 0; t++) begin
            tick();
            if (done_w[3]) seen = 1;
        end
        chk("bp_done_seen", seen, 1);
        chk("bp_words", acc3, 8);
        settle();

        // Stop in the cycle after the third word is accepted, then replay from 0.
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int t = 0; t < 20 && found == 0; t++) begin
            if (valid_w[3] && dat(3) == 2) found = 1;
            else tick();
        end
        chk("stop_reach_word2", found, 1);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_valid", int'(valid_w[3]), 0);
        chk("stop_busy", int'(busy_w[3]), 0);
        chk("stop_done", int'(done_w[3]), 0);
        tick();
        chk("stop_no_done", int'(done_w[3]), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("replay_valid", int'(valid_w[3]), 1);
        chk("replay_data", dat(3), 0);
        settle();

        // Asynchronous reset while u3 sits in its inter-word gap.
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int t = 0; t < 20 && found == 0; t++) begin
            tick();
            if (busy_w[3] && !valid_w[3]) found = 1;
        end
        chk("rst_reach_hold", found, 1);
        do_reset();
        chk("rst_valid", int'(valid_w[3]), 0);
        chk("rst_busy", int'(busy_w[3]), 0);
        chk("rst_done", int'(done_w[3]), 0);
        chk("rst_data", dat(3), 0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_replay_valid", int'(valid_w[3]), 1);
        chk("rst_replay_data", dat(3), 0);
        settle();

        // Randomised traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            start = (($urandom % 4) == 0);
            stop  = (($urandom % 24) == 0);
            ready = (($urandom % 4) != 0);
            if (($urandom % 150) == 0) do_reset();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
